// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder: format codes, opcodes and the canonical NOP.
package isa_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } packed_word_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for one instruction word, with optional immediate range check
// (enabled by defining INSTR_ENCODER_RANGE_CHECK_EN).
module instr_pack
    import isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic fmt_err_s;
    logic range_err_s;

    // Field placement per format; illegal formats collapse to a flagged NOP.
    always_comb begin
        instr     = NOP_WORD;
        fmt_err_s = 1'b0;
        case (fmt)
            FMT_R:        instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:        instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S, FMT_B: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_U, FMT_J: instr = {imm[19:0], rd, opcode};
            default: begin
                instr     = NOP_WORD;
                fmt_err_s = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Flag immediates that lose information when truncated into their field.
    always_comb begin
        range_err_s = 1'b0;
        case (fmt)
            FMT_I, FMT_S, FMT_B: range_err_s = ~((&imm[31:11]) | ~(|imm[31:11]));
            FMT_J:               range_err_s = ~((&imm[31:19]) | ~(|imm[31:19]));
            FMT_U:               range_err_s = |imm[31:20];
            default:             range_err_s = 1'b0;
        endcase
    end
`else
    logic unused_imm_s;
    assign range_err_s  = 1'b0;
    assign unused_imm_s = ^imm[31:20];
`endif

    assign err = fmt_err_s | range_err_s;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: single-register valid/ready stage around instr_pack, with word address
// and word counter. Optional immediate range check via INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_FULL  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [31:0]      instr_r;
    logic             err_r;
    logic [31:0]      addr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      pack_instr_s;
    logic             pack_err_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             hs_s;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .instr  (pack_instr_s),
        .err    (pack_err_s)
    );

    // Ready is withheld during reset and clear so no field-set slips into a flushed stage.
    assign in_ready_s = rst_n & ~clear & ((state_r == ST_EMPTY) | out_ready);
    assign accept_s   = in_valid & in_ready_s;
    assign hs_s       = (state_r == ST_FULL) & out_ready & ~clear;

    // Next-state: a handshake paired with a new accept keeps the stage full.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) state_nxt_s = ST_FULL;
                else          state_nxt_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (hs_s && !accept_s) state_nxt_s = ST_EMPTY;
                else                   state_nxt_s = ST_FULL;
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Output register, address and counter; clear takes priority over any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            instr_r <= 32'h0;
            err_r   <= 1'b0;
            addr_r  <= BASE_ADDR;
            cnt_r   <= CNT_ZERO;
        end else if (clear) begin
            state_r <= ST_EMPTY;
            instr_r <= 32'h0;
            err_r   <= 1'b0;
            addr_r  <= BASE_ADDR;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                instr_r <= pack_instr_s;
                err_r   <= pack_err_s;
            end
            if (hs_s) begin
                addr_r <= addr_r + 32'd4;
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_FULL);
    assign out_instr = instr_r;
    assign out_err   = err_r;
    assign out_addr  = addr_r;
    assign word_cnt  = cnt_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus randomized traffic against an
// arithmetic reference model; follows INSTR_ENCODER_RANGE_CHECK_EN when defined.
module tb_instr_encoder;
    import isa_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CW   = 16;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam logic RANGE_ON = 1'b1;
`else
    localparam logic RANGE_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]    fmt, funct3;
    logic [6:0]    opcode, funct7;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm, out_instr, out_addr;
    logic [CW-1:0] word_cnt;

    int          total = 0;
    int          bad = 0;
    int          popped = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_addr = BASE;
    int          exp_cnt = 0;

    instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: place each field by multiplying with its bit weight.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] im);
        exp_t        e;
        int unsigned u;
        int unsigned w;
        longint      sv;
        u     = im;
        sv    = longint'($signed(im));
        e.err = 1'b0;
        case (f)
            3'd0: w = 32'(op) + 32'(d) * 128 + 32'(f3) * 4096 + 32'(s1) * 32768
                      + 32'(s2) * 1048576 + 32'(f7) * 33554432;
            3'd1: w = 32'(op) + 32'(d) * 128 + 32'(f3) * 4096 + 32'(s1) * 32768
                      + (u % 4096) * 1048576;
            3'd2, 3'd3: w = 32'(op) + (u % 32) * 128 + 32'(f3) * 4096 + 32'(s1) * 32768
                      + 32'(s2) * 1048576 + ((u / 32) % 128) * 33554432;
            3'd4, 3'd5: w = 32'(op) + 32'(d) * 128 + (u % 1048576) * 4096;
            default: begin
                w     = 32'h13;
                e.err = 1'b1;
            end
        endcase
        if (RANGE_ON) begin
            if ((f == 3'd1 || f == 3'd2 || f == 3'd3) && (sv < -2048 || sv > 2047)) e.err = 1'b1;
            if (f == 3'd5 && (sv < -524288 || sv > 524287)) e.err = 1'b1;
            if (f == 3'd4 && u > 32'h000F_FFFF) e.err = 1'b1;
        end
        e.instr = w;
        return e;
    endfunction

    // One clock of stimulus: record an accepted field-set, then advance to just after the edge.
    task automatic cycle();
        #2;
        if (in_valid && in_ready)
            sb_q.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic rand_fields(input logic legal_only);
        logic [31:0] edges [10];
        int          sel;
        edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'h0007_FFFF,
                  32'h0008_0000, 32'hFFF8_0000, 32'hFFF7_FFFF, 32'h000F_FFFF, 32'h0010_0000};
        if (!legal_only && $urandom_range(0, 9) == 0) fmt = 3'($urandom_range(6, 7));
        else                                         fmt = 3'($urandom_range(0, 5));
        opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        sel = $urandom_range(0, 2);
        case (sel)
            0:       imm = $urandom;
            1:       imm = edges[$urandom_range(0, 9)];
            default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endtask

    task automatic flush_model();
        sb_q.delete();
        exp_addr = BASE;
        exp_cnt  = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_err"},   out_err,   1'b0);
        check({tag, "_out_addr"},  out_addr,  BASE);
        check({tag, "_word_cnt"},  32'(word_cnt), 32'd0);
        check({tag, "_in_ready"},  in_ready,  1'b0);
    endtask

    // Monitor: every completed output handshake is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !clear && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got word %h with no expected entry", out_instr);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_err",   out_err,   e.err);
                    check("sb_addr",  out_addr,  exp_addr);
                    check("sb_cnt",   32'(word_cnt), 32'(exp_cnt % (1 << CW)));
                end
                exp_addr = exp_addr + 32'd4;
                exp_cnt++;
                popped++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        in_valid = 1'b0;
        flush_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_vals("por");
        rst_n = 1'b1;
        cycle();

        // I-type word, then held off for three cycles
        set_fields(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF);
        cycle();
        in_valid = 1'b0;
        check("i_valid", out_valid, 1'b1);
        check("i_instr", out_instr, 32'hFFF0_8113);
        check("i_err",   out_err,   1'b0);
        check("i_addr",  out_addr,  BASE);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", in_ready, 1'b0);
            cycle();
            check("stall_valid", out_valid, 1'b1);
            check("stall_instr", out_instr, 32'hFFF0_8113);
            check("stall_addr",  out_addr,  BASE);
        end

        // Release: I leaves while S enters in the same cycle
        out_ready = 1'b1;
        set_fields(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h0, 32'd8);
        cycle();
        check("s_valid", out_valid, 1'b1);
        check("s_instr", out_instr, 32'h0051_2423);
        check("s_addr",  out_addr,  BASE + 32'd4);
        check("s_cnt",   32'(word_cnt), 32'd1);
        set_fields(3'd4, 7'h38, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0001_2345);
        cycle();
        check("u_instr", out_instr, 32'h1234_50B8);
        check("u_err",   out_err,   1'b0);
        check("u_addr",  out_addr,  BASE + 32'd8);
        set_fields(3'd4, 7'h38, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0010_0000);
        cycle();
        check("u_big_instr", out_instr, 32'h0000_00B8);
        check("u_big_err",   out_err,   RANGE_ON);
        set_fields(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'h0);
        cycle();
        check("ill_instr", out_instr, NOP_WORD);
        check("ill_err",   out_err,   1'b1);
        in_valid = 1'b0;
        cycle();
        check("drain_valid", out_valid, 1'b0);
        check("drain_cnt",   32'(word_cnt), 32'd5);

        // Reset pulse while a word is stalled
        out_ready = 1'b0;
        rand_fields(1'b1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        flush_model();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Back-to-back streaming of four words
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_fields(1'b0);
            in_valid = 1'b1;
            cycle();
            check("stream_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        check("stream_cnt",   32'(word_cnt), 32'd4);
        check("stream_empty", out_valid, 1'b0);
        check("stream_addr",  out_addr,  BASE + 32'd16);

        // Clear while full and stalled, with a competing in_valid
        out_ready = 1'b0;
        rand_fields(1'b1);
        in_valid = 1'b1;
        cycle();
        rand_fields(1'b1);
        check("pre_clr_valid", out_valid, 1'b1);
        clear = 1'b1;
        #1;
        check("clr_in_ready", in_ready, 1'b0);
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        flush_model();
        check("clr_valid", out_valid, 1'b0);
        check("clr_cnt",   32'(word_cnt), 32'd0);
        check("clr_addr",  out_addr,  BASE);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            rand_fields(1'b0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) cycle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("words_seen", 32'(popped >= 150), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, address assigned to the first emitted word after reset or clear.
REQ-002 SHALL have parameter CNT_W, default 16, width of the emitted-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of pending word, address and count.
REQ-006 SHALL have port in_valid / in_ready  input / output  1 / 1  field-set handshake.
REQ-007 SHALL have port fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-008 SHALL have ports opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, all inputs, instruction fields.
REQ-009 SHALL have port imm  input  32  sign-carrying immediate value.
REQ-010 SHALL have port out_valid / out_ready  output / input  1 / 1  word handshake.
REQ-011 SHALL have ports out_instr  output  32, out_addr  output  32, out_err  output  1, word_cnt  output  CNT_W.

Function
REQ-012 SHALL pack R as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-013 SHALL pack I as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-014 SHALL pack S and B identically as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-015 SHALL pack U and J identically as {imm[19:0], rd, opcode}, no bit scrambling.
REQ-016 SHALL, for illegal fmt, emit 32'h00000013 with out_err=1.
REQ-017 SHALL accept a field-set when in_valid && in_ready; latency 1 cycle to out_valid.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (single output register, full throughput).
REQ-019 SHALL hold out_instr, out_addr, out_err stable while out_valid && !out_ready.
REQ-020 SHALL increment the address by 4 and word_cnt by 1 on each out handshake; both wrap modulo width.
REQ-021 SHALL, for simultaneous out handshake and new accept, replace the word in the same cycle with no bubble.
REQ-022 SHALL, on clear, drop any pending word (out_valid=0), reset address to BASE_ADDR and word_cnt to 0, ignore in_valid that cycle, and hold in_ready=0 that cycle.
REQ-023 SHALL use two states, EMPTY and FULL: EMPTY->FULL on accept; FULL->EMPTY on out handshake without accept; FULL->FULL on handshake with accept or stall; any->EMPTY on clear.

Reset
REQ-024 SHALL, while rst_n=0, force state EMPTY, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, word_cnt=0, in_ready=0.
REQ-025 SHALL, on rst_n assertion mid-transfer, discard the pending word with no handshake completed.

Configuration
REQ-026 SHALL, with macro INSTR_ENCODER_RANGE_CHECK_EN defined, set out_err=1 when imm does not fit: I/S/B imm[31:11] not all equal; J imm[31:19] not all equal; U imm[31:20]!=0; R never. The word is still emitted with truncated imm.
REQ-027 SHALL, without INSTR_ENCODER_RANGE_CHECK_EN, set out_err only for illegal fmt.

Structure
REQ-028 SHALL place fmt codes, the NOP constant 32'h00000013 and the opcode constants in shared package isa_pkg.
REQ-029 SHALL place the combinational pack and range check in sub-module instr_pack, with the handshake register and counters in instr_encoder.

Verification
REQ-030 SHALL check I: fmt=1, op=0x13, rd=2, rs1=1, f3=0, imm=-1 -> out_instr=0xFFF08113, out_err=0, out_addr=BASE_ADDR.
REQ-031 SHALL check S: fmt=2, op=0x23, rs2=5, rs1=2, f3=2, imm=8 -> 0x00512423, and a following word at out_addr=BASE_ADDR+4.
REQ-032 SHALL check U: fmt=4, op=0x38, rd=1, imm=0x12345 -> 0x123450B8; imm=0x100000 -> out_err=1 only with the macro defined.
REQ-033 SHALL check backpressure: out_ready=0 for 3 cycles -> out_valid held, outputs stable, in_ready=0; then back-to-back streaming of 4 words with out_ready=1 -> one word per cycle, word_cnt=4.
REQ-034 SHALL check clear asserted while FULL and stalled -> next cycle out_valid=0, word_cnt=0, out_addr=BASE_ADDR.
REQ-035 SHALL check illegal fmt=7 -> 0x00000013 with out_err=1; rst_n pulse mid-stall -> all reset values of REQ-024.
